// File: rtl/forward_scoreboard_pkg.sv
// Shared constants for the operand forwarding / long-latency scoreboard block.
// Register-file select encoding and default pipeline geometry.
package forward_scoreboard_pkg;
    localparam int DEFAULT_REG_ADDR_WIDTH = 5;
    localparam int DEFAULT_NUM_SRC        = 2;
    localparam int DEFAULT_NUM_STAGES     = 2;
    localparam int DEFAULT_MAX_OUT        = 2;
    localparam int DEFAULT_CNT_WIDTH      = 16;
    localparam int FORWARD_SEL_RF         = 0;
endpackage

// File: rtl/forward_scoreboard_reg_scoreboard.sv
// Busy-bit array and outstanding-op counter for the long-latency unit.
// Kill beats set, set beats clear; register 0 is never marked busy.
module reg_scoreboard
    import forward_scoreboard_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH,
    parameter int NUM_LOOKUP = DEFAULT_NUM_SRC + 1,
    parameter int MAX_OUT    = DEFAULT_MAX_OUT,
    parameter int CNT_W      = $clog2(MAX_OUT + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             set_valid,
    input  logic [ADDR_WIDTH-1:0]            set_addr,
    input  logic                             clr_valid,
    input  logic [ADDR_WIDTH-1:0]            clr_addr,
    input  logic                             kill,
    input  logic [NUM_LOOKUP*ADDR_WIDTH-1:0] lookup_addr,
    output logic [NUM_LOOKUP-1:0]            lookup_busy,
    output logic [CNT_W-1:0]                 busy_cnt
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [NUM_REGS-1:0] busy_r;
    logic [NUM_REGS-1:0] busy_nxt_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_nxt_s;
    logic                clr_ok_s;

    // A writeback with nothing outstanding is dropped so the count cannot wrap.
    assign clr_ok_s = clr_valid && (cnt_r != '0);

    // Next busy vector per register.
    always_comb begin
        busy_nxt_s = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (kill) begin
                busy_nxt_s[r] = 1'b0;
            end else if (set_valid && (set_addr == ADDR_WIDTH'(r))) begin
                busy_nxt_s[r] = 1'b1;
            end else if (clr_ok_s && (clr_addr == ADDR_WIDTH'(r))) begin
                busy_nxt_s[r] = 1'b0;
            end else begin
                busy_nxt_s[r] = busy_r[r];
            end
        end
    end

    // Next outstanding count; a simultaneous set and clear cancel out.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (kill) begin
            cnt_nxt_s = '0;
        end else if (set_valid && !clr_ok_s) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end else if (clr_ok_s && !set_valid) begin
            cnt_nxt_s = cnt_r - CNT_W'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Scoreboard state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= '0;
            cnt_r  <= '0;
        end else begin
            busy_r <= busy_nxt_s;
            cnt_r  <= cnt_nxt_s;
        end
    end

    // Combinational busy lookup for each requested address.
    always_comb begin
        lookup_busy = '0;
        for (int j = 0; j < NUM_LOOKUP; j++) begin
            lookup_busy[j] = busy_r[lookup_addr[j*ADDR_WIDTH +: ADDR_WIDTH]];
        end
    end

    assign busy_cnt = cnt_r;
endmodule

// File: rtl/forward_scoreboard.sv
// Operand bypass selection, load-use and long-unit hazard detection,
// and a saturating stall-cycle counter sitting between ID/EX and the EX muxes.
module forward_scoreboard
    import forward_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH,
    parameter int NUM_SRC        = DEFAULT_NUM_SRC,
    parameter int NUM_STAGES     = DEFAULT_NUM_STAGES,
    parameter int SEL_WIDTH      = $clog2(NUM_STAGES + 1),
    parameter int MAX_OUT        = DEFAULT_MAX_OUT,
    parameter int CNT_WIDTH      = DEFAULT_CNT_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0]    rs_addr,
    input  logic [NUM_SRC-1:0]                   rs_used,
    input  logic [NUM_STAGES*REG_ADDR_WIDTH-1:0] stg_rd_addr,
    input  logic [NUM_STAGES-1:0]                stg_we,
    input  logic                                 stg1_is_load,
    input  logic                                 issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0]            issue_rd,
    input  logic                                 lu_wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0]            lu_wb_rd,
    input  logic                                 lu_kill,
    input  logic                                 cnt_clr,
    output logic [NUM_SRC*SEL_WIDTH-1:0]         fwd_sel,
    output logic                                 stall,
    output logic                                 issue_ack,
    output logic [$clog2(MAX_OUT+1)-1:0]         busy_cnt,
    output logic [CNT_WIDTH-1:0]                 stall_cycles
);
    localparam int BUSY_W = $clog2(MAX_OUT + 1);
    localparam int AW     = REG_ADDR_WIDTH;

    logic [NUM_SRC-1:0][NUM_STAGES-1:0] match_s;
    logic [NUM_SRC*SEL_WIDTH-1:0]       fwd_sel_s;
    logic [NUM_SRC:0]                   lookup_busy_s;
    logic [BUSY_W-1:0]                  busy_cnt_s;
    logic                               load_use_s;
    logic                               raw_s;
    logic                               waw_s;
    logic                               struct_s;
    logic                               stall_s;
    logic                               issue_ack_s;
    logic [CNT_WIDTH-1:0]               stall_cycles_r;

    // Qualified source/stage matches; x0 never forwards.
    always_comb begin
        match_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                match_s[i][k] = rs_used[i] && stg_we[k]
                             && (rs_addr[i*AW +: AW] == stg_rd_addr[k*AW +: AW])
                             && (rs_addr[i*AW +: AW] != '0);
            end
        end
    end

    // Youngest stage wins: scan oldest to youngest so later hits override.
    always_comb begin
        fwd_sel_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            fwd_sel_s[i*SEL_WIDTH +: SEL_WIDTH] = SEL_WIDTH'(FORWARD_SEL_RF);
            for (int k = NUM_STAGES - 1; k >= 0; k--) begin
                fwd_sel_s[i*SEL_WIDTH +: SEL_WIDTH] = match_s[i][k] ? SEL_WIDTH'(k + 1)
                                                    : fwd_sel_s[i*SEL_WIDTH +: SEL_WIDTH];
            end
        end
    end

    // Load-use: any source hitting a load in the youngest stage.
    always_comb begin
        load_use_s = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            load_use_s = load_use_s | (stg1_is_load & match_s[i][0]);
        end
    end

    reg_scoreboard #(
        .ADDR_WIDTH (AW),
        .NUM_LOOKUP (NUM_SRC + 1),
        .MAX_OUT    (MAX_OUT),
        .CNT_W      (BUSY_W)
    ) u_reg_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_valid   (issue_ack_s),
        .set_addr    (issue_rd),
        .clr_valid   (lu_wb_valid),
        .clr_addr    (lu_wb_rd),
        .kill        (lu_kill),
        .lookup_addr ({issue_rd, rs_addr}),
        .lookup_busy (lookup_busy_s),
        .busy_cnt    (busy_cnt_s)
    );

    assign raw_s       = |(rs_used & lookup_busy_s[NUM_SRC-1:0]);
    assign waw_s       = issue_valid && lookup_busy_s[NUM_SRC];
    assign struct_s    = issue_valid && (busy_cnt_s == BUSY_W'(MAX_OUT));
    assign stall_s     = load_use_s | raw_s | waw_s | struct_s;
    assign issue_ack_s = issue_valid && !stall_s && !lu_kill;

    // Saturating stall-cycle counter; clear has priority over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_r <= '0;
        end else if (cnt_clr) begin
            stall_cycles_r <= '0;
        end else if (stall_s && !(&stall_cycles_r)) begin
            stall_cycles_r <= stall_cycles_r + CNT_WIDTH'(1);
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign fwd_sel      = fwd_sel_s;
    assign stall        = stall_s;
    assign issue_ack    = issue_ack_s;
    assign busy_cnt     = busy_cnt_s;
    assign stall_cycles = stall_cycles_r;
endmodule

// File: tb/tb_forward_scoreboard.sv
// Self-checking bench for forward_scoreboard: directed scenarios plus a
// randomized run against a behavioural forwarding/scoreboard model.
module tb_forward_scoreboard;
    localparam int AW = 5;
    localparam int NS = 2;
    localparam int NG = 2;
    localparam int SW = 2;
    localparam int MO = 2;
    localparam int CW = 10;
    localparam int BW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NS*AW-1:0] rs_addr;
    logic [NS-1:0]    rs_used;
    logic [NG*AW-1:0] stg_rd_addr;
    logic [NG-1:0]    stg_we;
    logic             stg1_is_load;
    logic             issue_valid;
    logic [AW-1:0]    issue_rd;
    logic             lu_wb_valid;
    logic [AW-1:0]    lu_wb_rd;
    logic             lu_kill;
    logic             cnt_clr;
    logic [NS*SW-1:0] fwd_sel;
    logic             stall;
    logic             issue_ack;
    logic [BW-1:0]    busy_cnt;
    logic [CW-1:0]    stall_cycles;

    int checks = 0;
    int fails  = 0;

    forward_scoreboard #(
        .REG_ADDR_WIDTH (AW),
        .NUM_SRC        (NS),
        .NUM_STAGES     (NG),
        .SEL_WIDTH      (SW),
        .MAX_OUT        (MO),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rs_addr      (rs_addr),
        .rs_used      (rs_used),
        .stg_rd_addr  (stg_rd_addr),
        .stg_we       (stg_we),
        .stg1_is_load (stg1_is_load),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .lu_wb_valid  (lu_wb_valid),
        .lu_wb_rd     (lu_wb_rd),
        .lu_kill      (lu_kill),
        .cnt_clr      (cnt_clr),
        .fwd_sel      (fwd_sel),
        .stall        (stall),
        .issue_ack    (issue_ack),
        .busy_cnt     (busy_cnt),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic idle();
        rs_addr = '0; rs_used = '0; stg_rd_addr = '0; stg_we = '0;
        stg1_is_load = 1'b0; issue_valid = 1'b0; issue_rd = '0;
        lu_wb_valid = 1'b0; lu_wb_rd = '0; lu_kill = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #3;
        checks++; if (busy_cnt !== 2'd0) begin fails++; $display("FAIL reset_busy_cnt: got %0d want 0", busy_cnt); end
        checks++; if (stall_cycles !== 10'd0) begin fails++; $display("FAIL reset_stall_cycles: got %0d want 0", stall_cycles); end
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %0b want 0", stall); end
        checks++; if (fwd_sel !== 4'd0) begin fails++; $display("FAIL reset_fwd_sel: got %0h want 0", fwd_sel); end
        cyc();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_forward();
        do_reset();
        rs_addr = {5'd0, 5'd5}; rs_used = 2'b01;
        stg_rd_addr = {5'd5, 5'd5}; stg_we = 2'b11;
        #1;
        checks++; if (fwd_sel[1:0] !== 2'd1) begin fails++; $display("FAIL fwd_youngest: got %0d want 1", fwd_sel[1:0]); end
        stg_we = 2'b10;
        #1;
        checks++; if (fwd_sel[1:0] !== 2'd2) begin fails++; $display("FAIL fwd_stage2: got %0d want 2", fwd_sel[1:0]); end
        rs_used = 2'b00;
        #1;
        checks++; if (fwd_sel[1:0] !== 2'd0) begin fails++; $display("FAIL fwd_unused: got %0d want 0", fwd_sel[1:0]); end
        rs_addr = {5'd0, 5'd0}; rs_used = 2'b01;
        stg_rd_addr = {5'd0, 5'd0}; stg_we = 2'b01; stg1_is_load = 1'b1;
        #1;
        checks++; if (fwd_sel !== 4'd0) begin fails++; $display("FAIL fwd_x0: got %0h want 0", fwd_sel); end
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL stall_x0: got %0b want 0", stall); end
        rs_addr = {5'd7, 5'd0}; rs_used = 2'b10;
        stg_rd_addr = {5'd0, 5'd7}; stg_we = 2'b00; stg1_is_load = 1'b0;
        #1;
        checks++; if (fwd_sel[3:2] !== 2'd0) begin fails++; $display("FAIL fwd_no_we: got %0d want 0", fwd_sel[3:2]); end
        idle();
    endtask

    task automatic test_load_use();
        do_reset();
        rs_addr = {5'd3, 5'd0}; rs_used = 2'b10;
        stg_rd_addr = {5'd0, 5'd3}; stg_we = 2'b01; stg1_is_load = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) begin fails++; $display("FAIL load_use_stall: got %0b want 1", stall); end
        checks++; if (fwd_sel[3:2] !== 2'd1) begin fails++; $display("FAIL load_use_sel: got %0d want 1", fwd_sel[3:2]); end
        cyc();
        stg_rd_addr = {5'd3, 5'd0}; stg_we = 2'b10; stg1_is_load = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL load_moved_stall: got %0b want 0", stall); end
        checks++; if (fwd_sel[3:2] !== 2'd2) begin fails++; $display("FAIL load_moved_sel: got %0d want 2", fwd_sel[3:2]); end
        checks++; if (stall_cycles !== 10'd1) begin fails++; $display("FAIL load_use_count: got %0d want 1", stall_cycles); end
        idle();
    endtask

    task automatic test_long_raw();
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd9;
        #1;
        checks++; if (issue_ack !== 1'b1) begin fails++; $display("FAIL raw_issue_ack: got %0b want 1", issue_ack); end
        cyc();
        issue_valid = 1'b0; rs_addr = {5'd0, 5'd9}; rs_used = 2'b01;
        #1;
        checks++; if (busy_cnt !== 2'd1) begin fails++; $display("FAIL raw_busy_cnt: got %0d want 1", busy_cnt); end
        for (int n = 0; n < 3; n++) begin
            #1;
            checks++; if (stall !== 1'b1) begin fails++; $display("FAIL raw_stall_hold: got %0b want 1", stall); end
            cyc();
        end
        lu_wb_valid = 1'b1; lu_wb_rd = 5'd9;
        #1;
        checks++; if (stall !== 1'b1) begin fails++; $display("FAIL raw_stall_wb_cycle: got %0b want 1", stall); end
        cyc();
        lu_wb_valid = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL raw_released: got %0b want 0", stall); end
        checks++; if (busy_cnt !== 2'd0) begin fails++; $display("FAIL raw_cnt_back: got %0d want 0", busy_cnt); end
        checks++; if (stall_cycles !== 10'd4) begin fails++; $display("FAIL raw_stall_count: got %0d want 4", stall_cycles); end
        idle();
    endtask

    task automatic test_structural();
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd4;
        #1;
        checks++; if (issue_ack !== 1'b1) begin fails++; $display("FAIL struct_ack4: got %0b want 1", issue_ack); end
        cyc();
        issue_rd = 5'd6;
        #1;
        checks++; if (issue_ack !== 1'b1) begin fails++; $display("FAIL struct_ack6: got %0b want 1", issue_ack); end
        cyc();
        issue_rd = 5'd8;
        #1;
        checks++; if (busy_cnt !== 2'd2) begin fails++; $display("FAIL struct_cnt_full: got %0d want 2", busy_cnt); end
        checks++; if (stall !== 1'b1 || issue_ack !== 1'b0) begin fails++; $display("FAIL struct_full_stall: got stall=%0b ack=%0b want stall=1 ack=0", stall, issue_ack); end
        cyc();
        lu_wb_valid = 1'b1; lu_wb_rd = 5'd4;
        #1;
        checks++; if (issue_ack !== 1'b0) begin fails++; $display("FAIL struct_wb_cycle_ack: got %0b want 0", issue_ack); end
        cyc();
        lu_wb_valid = 1'b0;
        #1;
        checks++; if (busy_cnt !== 2'd1 || issue_ack !== 1'b1) begin fails++; $display("FAIL struct_ack_after_wb: got cnt=%0d ack=%0b want cnt=1 ack=1", busy_cnt, issue_ack); end
        cyc();
        issue_valid = 1'b0; lu_wb_valid = 1'b1; lu_wb_rd = 5'd8;
        cyc();
        lu_wb_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd6;
        #1;
        checks++; if (busy_cnt !== 2'd1 || stall !== 1'b1 || issue_ack !== 1'b0) begin fails++; $display("FAIL waw_stall: got cnt=%0d stall=%0b ack=%0b want 1 1 0", busy_cnt, stall, issue_ack); end
        idle();
    endtask

    task automatic test_same_cycle_and_kill();
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd11;
        cyc();
        issue_rd = 5'd10; lu_wb_valid = 1'b1; lu_wb_rd = 5'd10;
        #1;
        checks++; if (issue_ack !== 1'b1) begin fails++; $display("FAIL same_cycle_ack: got %0b want 1", issue_ack); end
        cyc();
        issue_valid = 1'b0; lu_wb_valid = 1'b0; rs_addr = {5'd0, 5'd10}; rs_used = 2'b01;
        #1;
        checks++; if (busy_cnt !== 2'd1) begin fails++; $display("FAIL same_cycle_cnt: got %0d want 1", busy_cnt); end
        checks++; if (stall !== 1'b1) begin fails++; $display("FAIL same_cycle_set_wins: got %0b want 1", stall); end
        rs_used = 2'b00; issue_valid = 1'b1; issue_rd = 5'd12; lu_kill = 1'b1;
        #1;
        checks++; if (issue_ack !== 1'b0) begin fails++; $display("FAIL kill_ack: got %0b want 0", issue_ack); end
        cyc();
        lu_kill = 1'b0; issue_valid = 1'b0; rs_used = 2'b01;
        #1;
        checks++; if (busy_cnt !== 2'd0 || stall !== 1'b0) begin fails++; $display("FAIL kill_clears: got cnt=%0d stall=%0b want 0 0", busy_cnt, stall); end
        rs_used = 2'b00; lu_wb_valid = 1'b1; lu_wb_rd = 5'd5;
        cyc();
        lu_wb_valid = 1'b0;
        #1;
        checks++; if (busy_cnt !== 2'd0) begin fails++; $display("FAIL wb_no_underflow: got %0d want 0", busy_cnt); end
        issue_valid = 1'b1; issue_rd = 5'd0;
        cyc();
        issue_valid = 1'b0;
        #1;
        checks++; if (busy_cnt !== 2'd1) begin fails++; $display("FAIL issue_x0_counts: got %0d want 1", busy_cnt); end
        idle();
    endtask

    task automatic test_saturation();
        logic [CW-1:0] all_ones;
        all_ones = '1;
        do_reset();
        rs_addr = {5'd0, 5'd3}; rs_used = 2'b01;
        stg_rd_addr = {5'd0, 5'd3}; stg_we = 2'b01; stg1_is_load = 1'b1;
        for (int n = 0; n < (2 ** CW) + 5; n++) cyc();
        checks++; if (stall_cycles !== all_ones) begin fails++; $display("FAIL stall_saturate: got %0d want %0d", stall_cycles, all_ones); end
        cnt_clr = 1'b1;
        cyc();
        checks++; if (stall_cycles !== 10'd0) begin fails++; $display("FAIL cnt_clr_wins: got %0d want 0", stall_cycles); end
        cnt_clr = 1'b0;
        cyc();
        checks++; if (stall_cycles !== 10'd1) begin fails++; $display("FAIL count_resumes: got %0d want 1", stall_cycles); end
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd9;
        cyc();
        issue_valid = 1'b0; rs_addr = {5'd0, 5'd9}; rs_used = 2'b01;
        #1;
        checks++; if (stall !== 1'b1) begin fails++; $display("FAIL pre_reset_stall: got %0b want 1", stall); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy_cnt !== 2'd0 || stall !== 1'b0) begin fails++; $display("FAIL async_reset: got cnt=%0d stall=%0b want 0 0", busy_cnt, stall); end
        cyc();
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_random();
        bit            mb [32];
        int            mcnt;
        int            msc;
        int            ef [NS];
        bit            est;
        bit            eack;
        logic [AW-1:0] a [NS];
        logic [AW-1:0] d [NG];
        do_reset();
        foreach (mb[r]) mb[r] = 1'b0;
        mcnt = 0;
        msc  = 0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NS; i++) a[i] = 5'($urandom_range(0, 7));
            for (int k = 0; k < NG; k++) d[k] = 5'($urandom_range(0, 7));
            rs_addr      = {a[1], a[0]};
            stg_rd_addr  = {d[1], d[0]};
            rs_used      = 2'($urandom);
            stg_we       = 2'($urandom);
            stg1_is_load = ($urandom % 4) == 0;
            issue_valid  = ($urandom % 2) == 0;
            issue_rd     = 5'($urandom_range(0, 7));
            lu_wb_valid  = ($urandom % 3) == 0;
            lu_wb_rd     = 5'($urandom_range(0, 7));
            lu_kill      = ($urandom % 25) == 0;
            cnt_clr      = ($urandom % 40) == 0;
            #1;
            est = 1'b0;
            for (int i = 0; i < NS; i++) begin
                ef[i] = 0;
                for (int k = 1; k <= NG; k++) begin
                    if (ef[i] == 0 && rs_used[i] && stg_we[k-1] && a[i] == d[k-1] && a[i] != 0) ef[i] = k;
                end
                if (ef[i] == 1 && stg1_is_load) est = 1'b1;
                if (rs_used[i] && mb[a[i]]) est = 1'b1;
            end
            if (issue_valid && (mb[issue_rd] || mcnt == MO)) est = 1'b1;
            eack = issue_valid && !est && !lu_kill;
            checks++; if (fwd_sel !== {2'(ef[1]), 2'(ef[0])}) begin fails++; $display("FAIL rand_fwd_sel[%0d]: got %0h want %0h", n, fwd_sel, {2'(ef[1]), 2'(ef[0])}); end
            checks++; if (stall !== est) begin fails++; $display("FAIL rand_stall[%0d]: got %0b want %0b", n, stall, est); end
            checks++; if (issue_ack !== eack) begin fails++; $display("FAIL rand_ack[%0d]: got %0b want %0b", n, issue_ack, eack); end
            checks++; if (busy_cnt !== 2'(mcnt)) begin fails++; $display("FAIL rand_busy_cnt[%0d]: got %0d want %0d", n, busy_cnt, mcnt); end
            checks++; if (stall_cycles !== 10'(msc)) begin fails++; $display("FAIL rand_stall_cycles[%0d]: got %0d want %0d", n, stall_cycles, msc); end
            @(posedge clk);
            if (lu_kill) begin
                foreach (mb[r]) mb[r] = 1'b0;
                mcnt = 0;
            end else begin
                if (lu_wb_valid && mcnt > 0) begin
                    mb[lu_wb_rd] = 1'b0;
                    mcnt--;
                end
                if (eack) begin
                    if (issue_rd != 0) mb[issue_rd] = 1'b1;
                    mcnt++;
                end
            end
            if (cnt_clr) msc = 0;
            else if (est && msc < (2 ** CW) - 1) msc++;
            #1;
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_forward();
        test_load_use();
        test_long_raw();
        test_structural();
        test_same_cycle_and_kill();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/forward_scoreboard.md
# forward_scoreboard

Parametrised successor to the two-source EX-stage forwarding unit. It produces per-source bypass selects across a configurable number of downstream stages. Unlike the earlier unit, it qualifies every match with write-enable and suppresses matches on x0. It adds load-use stall detection and a register scoreboard for a multi-cycle (mul/div) unit with RAW, WAW and structural stalls, plus a saturating stall-cycle counter. It sits between ID/EX decode and the EX operand muxes and drives the pipeline stall.

## Interface
- REG_ADDR_WIDTH, 5, register address width; register file has 2**REG_ADDR_WIDTH entries
- NUM_SRC, 2, number of source operands checked
- NUM_STAGES, 2, forwarding stages; stage 1 = MEM (youngest), stage NUM_STAGES = WB
- SEL_WIDTH, $clog2(NUM_STAGES+1), width of each forward select
- MAX_OUT, 2, maximum outstanding long-latency ops
- CNT_WIDTH, 16, stall counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- rs_addr  in  NUM_SRC*REG_ADDR_WIDTH  source addresses; source i at slice i
- rs_used  in  NUM_SRC  source i is read by the instruction
- stg_rd_addr  in  NUM_STAGES*REG_ADDR_WIDTH  destination of stage k at slice k-1
- stg_we  in  NUM_STAGES  stage k writes a register
- stg1_is_load  in  1  stage-1 instruction is a load
- issue_valid  in  1  ID instruction targets the long-latency unit
- issue_rd  in  REG_ADDR_WIDTH  its destination
- lu_wb_valid  in  1  long unit writes back this cycle
- lu_wb_rd  in  REG_ADDR_WIDTH  writeback destination
- lu_kill  in  1  abort all long-unit ops (flush)
- cnt_clr  in  1  synchronous clear of stall counter
- fwd_sel  out  NUM_SRC*SEL_WIDTH  0 = register file, k = stage k
- stall  out  1  hold IF/ID, bubble into EX
- issue_ack  out  1  issue accepted this cycle
- busy_cnt  out  $clog2(MAX_OUT+1)  outstanding long ops
- stall_cycles  out  CNT_WIDTH  saturating count of stalled cycles

## Operation
- Source i matches stage k when all of the following hold: rs_used[i], stg_we[k], rs_addr[i]==stg_rd_addr[k], rs_addr[i]!=0.
- fwd_sel[i] = the lowest matching k (youngest wins), else 0. The result is purely combinational.
- Load-use: stall when any source matches stage 1 and stg1_is_load=1.
- Scoreboard: busy bit per register; bit 0 is never set.
- RAW stall: any used source with its busy bit set. There is no same-cycle writeback bypass: a bit cleared at edge t still stalls during cycle t.
- WAW stall: issue_valid && busy[issue_rd].
- Structural stall: issue_valid && busy_cnt==MAX_OUT.
- stall = load-use | RAW | WAW | structural.
- issue_ack = issue_valid & ~stall. On issue_ack, set busy[issue_rd] (unless issue_rd==0) and increment busy_cnt.
- On lu_wb_valid, clear busy[lu_wb_rd] and decrement busy_cnt.
- Simultaneous issue_ack and lu_wb_valid on the same rd: the set wins, and busy_cnt is unchanged.
- issue_ack to rd 0 still counts in busy_cnt but sets no bit.
- lu_kill: clear all busy bits and busy_cnt=0; it overrides same-cycle issue and writeback. issue_ack is forced 0 that cycle.
- lu_wb_valid with busy_cnt==0 is ignored, and the count does not underflow.
- stall_cycles increments each cycle stall=1 and saturates at all-ones. cnt_clr wins over increment.

## Timing
- Reset: busy bits 0, busy_cnt 0, stall_cycles 0. Combinational outputs follow the inputs (fwd_sel 0, stall 0 with idle inputs).
- fwd_sel, stall and issue_ack are same-cycle combinational. Scoreboard, busy_cnt and stall_cycles update on the rising clk edge.
- Load-use stall lasts exactly one cycle, since the load then moves to stage 2 and forwards with select 2.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.

## Structure
- Shared `riscv_define` additions: FORWARD_SEL_RF=0 and default NUM_STAGES/MAX_OUT; the existing REG_ADDR_WIDTH is reused.
- One sub-module, reg_scoreboard: busy bit array and counter, with set/clear/kill ports and combinational lookup of NUM_SRC+1 addresses.
- Forward priority, stall combine and stall counter live in the top level.

## Test plan
- rs1=5 with stage1 rd=5 (we=1) and stage2 rd=5 (we=1) -> fwd_sel[0]=1. Then drop stage1 we -> fwd_sel[0]=2.
- rs1=0 with stage1 rd=0 (we=1) -> fwd_sel 0, no stall. rs2=7 with stage1 rd=7, we=0 -> fwd_sel[1]=0.
- Stage1 load rd=3, rs2=3 used -> stall=1 for one cycle, stall_cycles=1. Next cycle load in stage 2 -> fwd_sel[1]=2, stall=0.
- Issue rd=9 (ack, busy_cnt=1). rs1=9 -> stall until the edge after lu_wb_valid rd=9, including the writeback cycle. busy_cnt returns to 0.
- MAX_OUT=2: issue rd=4 and rd=6. Third issue rd=8 -> stall, no ack. Writeback rd=4 -> ack the next cycle. Issue rd=6 while busy -> WAW stall.
- Same-cycle issue and writeback on rd=10 -> busy[10]=1, busy_cnt unchanged. lu_kill with issue_valid -> busy_cnt=0, no ack.
- Hold stall for 2**CNT_WIDTH+5 cycles -> stall_cycles saturates at all-ones. cnt_clr -> 0.
- Reset asserted mid-sequence -> busy_cnt=0 and stall=0 before the next edge.
